// File: rtl/mau_pkg.sv
// Shared codes and state encoding for the MEM-stage data-memory access unit.
package mau_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int LD_EN_BIT = 3;
  localparam int ST_EN_BIT = 2;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational lane select and sign/zero extension of the bus read word.
// Zero latency; no flow control.
module load_align
  import mau_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'h0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage req/ack data-memory access; min 3 cycles (2 stalled + DONE), STALL held until BUS_ACK.
// MAU_MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of masking the low address bits.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] MEM_ALU_OUT,
  input  logic [DATA_W-1:0] MEM_REG_DATA2,
  input  logic [3:0]        MEM_DATA_MEM_READ,
  input  logic [2:0]        MEM_DATA_MEM_WRITE,
  output logic              BUS_REQ,
  output logic              BUS_WE,
  output logic [ADDR_W-1:0] BUS_ADDR,
  output logic [3:0]        BUS_BYTE_EN,
  output logic [DATA_W-1:0] BUS_WDATA,
  input  logic              BUS_ACK,
  input  logic [DATA_W-1:0] BUS_RDATA,
  output logic [DATA_W-1:0] LOAD_DATA,
  output logic              STALL,
  output logic              MISALIGNED
);

  logic              ld_en, st_en, access, trap, go;
  logic              capture, finish;
  logic [1:0]        size, off, lane_off;
  logic [3:0]        be;
  logic [DATA_W-1:0] wd, ld_ext;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  state_t            state, next_state;

  // A load wins when both enables are set.
  assign ld_en  = MEM_DATA_MEM_READ[LD_EN_BIT];
  assign st_en  = MEM_DATA_MEM_WRITE[ST_EN_BIT];
  assign access = ld_en | st_en;
  assign size   = ld_en ? MEM_DATA_MEM_READ[1:0] : MEM_DATA_MEM_WRITE[1:0];
  assign off    = MEM_ALU_OUT[1:0];

`ifdef MAU_MISALIGN_TRAP_EN
  assign trap = access &&
                (((size == SZ_H) && off[0]) ||
                 ((size != SZ_B) && (size != SZ_H) && (off != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  assign MISALIGNED = trap;
  assign go         = access & ~trap;
  assign STALL      = go & (state != DONE);

  always_comb begin
    lane_off = 2'b00;
    be       = 4'b1111;
    wd       = MEM_REG_DATA2;
    case (size)
      SZ_B: begin
        lane_off = off;
        be       = 4'b0001 << lane_off;
        wd       = {4{MEM_REG_DATA2[7:0]}};
      end
      SZ_H: begin
        lane_off = {off[1], 1'b0};
        be       = 4'b0011 << lane_off;
        wd       = {2{MEM_REG_DATA2[15:0]}};
      end
      default: begin
        lane_off = 2'b00;
        be       = 4'b1111;
        wd       = MEM_REG_DATA2;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          next_state = WAIT;
          capture    = 1'b1;
        end
      end
      WAIT: begin
        if (BUS_ACK) begin
          next_state = DONE;
          finish     = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  load_align u_load_align (
    .rdata  (BUS_RDATA),
    .offset (off_q),
    .funct3 (funct3_q),
    .data   (ld_ext)
  );

  // Bus fields are captured once and held for the whole transaction.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      BUS_REQ     <= 1'b0;
      BUS_WE      <= 1'b0;
      BUS_ADDR    <= '0;
      BUS_BYTE_EN <= 4'b0000;
      BUS_WDATA   <= '0;
      LOAD_DATA   <= '0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
    end else begin
      if (capture) begin
        BUS_REQ     <= 1'b1;
        BUS_WE      <= ~ld_en;
        BUS_ADDR    <= {MEM_ALU_OUT[ADDR_W-1:2], 2'b00};
        BUS_BYTE_EN <= be;
        BUS_WDATA   <= wd;
        funct3_q    <= MEM_DATA_MEM_READ[2:0];
        off_q       <= lane_off;
      end
      if (finish) begin
        BUS_REQ <= 1'b0;
        if (!BUS_WE) LOAD_DATA <= ld_ext;
      end
    end
  end

endmodule
